// File: rtl/booth_pkg.sv
// Shared widths, default latency and FSM state type for the Booth multiplier sequencer.
package booth_pkg;

    localparam int OPW            = 8;
    localparam int PRODW          = 16;
    localparam int MUL_CYCLES_DEF = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/booth_op_fifo.sv
// Operand-pair FIFO: power-of-2 depth, pointers wrap naturally.
module booth_op_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/booth_mul_sequencer.sv
// Operand sequencer for the 8x8 sequential Booth multiplier.
// Optional zero-operand shortcut: define BOOTH_SEQ_ZERO_BYPASS_EN.
module booth_mul_sequencer
    import booth_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [OPW-1:0]   op_a,
    input  logic [OPW-1:0]   op_b,
    output logic             mul_load,
    output logic [OPW-1:0]   mul_a,
    output logic [OPW-1:0]   mul_b,
    input  logic [PRODW-1:0] mul_product,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [PRODW-1:0] res_product,
    output logic             busy
);

    localparam int CW = $clog2(MUL_CYCLES + 1);
    localparam int FW = 2 * OPW;

    seq_state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OPW-1:0]   mul_a_q, mul_a_d;
    logic [OPW-1:0]   mul_b_q, mul_b_d;
    logic             mul_load_q, mul_load_d;
    logic             res_valid_q, res_valid_d;
    logic [PRODW-1:0] res_product_q, res_product_d;

    logic                          take;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [FW-1:0]                 head;
    logic [OPW-1:0]                head_a;
    logic [OPW-1:0]                head_b;
    logic                          head_zero;

    booth_op_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (op_valid),
        .din_i   ({op_a, op_b}),
        .pop_i   (take),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_a = head[FW-1:OPW];
    assign head_b = head[OPW-1:0];

`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
    assign head_zero = (head_a == '0) || (head_b == '0);
`else
    assign head_zero = 1'b0;
`endif

    assign op_ready    = !fifo_full;
    assign mul_load    = mul_load_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign res_valid   = res_valid_q;
    assign res_product = res_product_q;
    assign busy        = (state_q != S_IDLE) || (fifo_count != '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_load_d    = 1'b0;
        res_valid_d   = res_valid_q;
        res_product_d = res_product_q;
        take          = 1'b0;

        case (state_q)
            S_IDLE: take = !fifo_empty;
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(MUL_CYCLES - 1)) begin
                    res_product_d = mul_product;
                    res_valid_d   = 1'b1;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    take        = !fifo_empty;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop always reloads the operand registers, from IDLE or DONE alike.
        if (take) begin
            mul_a_d = head_a;
            mul_b_d = head_b;
            if (head_zero) begin
                state_d       = S_DONE;
                res_valid_d   = 1'b1;
                res_product_d = '0;
            end else begin
                state_d    = S_ISSUE;
                mul_load_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_load_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mul_load_q    <= mul_load_d;
            res_valid_q   <= res_valid_d;
            res_product_q <= res_product_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Directed bench for booth_mul_sequencer with a behavioural Booth multiplier.
module tb_booth_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        mul_load;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_product;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_product;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int loads  = 0;

    logic [3:0] m_cnt;
    logic [7:0] m_a;
    logic [7:0] m_b;

    booth_mul_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .mul_load    (mul_load),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Radix-2 Booth recoding on a 9-bit accumulator so -128 can be negated.
    function automatic logic [15:0] booth(input logic [7:0] a, input logic [7:0] b);
        logic [17:0] p;
        logic [8:0]  a9;
        p  = {9'b0, b, 1'b0};
        a9 = {a[7], a};
        for (int i = 0; i < 8; i++) begin
            case (p[1:0])
                2'b01:   p[17:9] = p[17:9] + a9;
                2'b10:   p[17:9] = p[17:9] - a9;
                default: p[17:9] = p[17:9];
            endcase
            p = {p[17], p[17:1]};
        end
        return p[16:1];
    endfunction

    // Multiplier model: product valid 9 edges after the load edge, junk before.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt       <= 4'd0;
            m_a         <= 8'd0;
            m_b         <= 8'd0;
            mul_product <= 16'd0;
        end else if (mul_load) begin
            m_cnt       <= 4'd9;
            m_a         <= mul_a;
            m_b         <= mul_b;
            mul_product <= 16'hA5A5;
        end else if (m_cnt != 4'd0) begin
            m_cnt <= m_cnt - 4'd1;
            if (m_cnt == 4'd1) mul_product <= booth(m_a, m_b);
        end
    end

    always @(posedge clk) begin
        if (mul_load) loads <= loads + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        while (!op_ready && n < 100) begin
            step();
            n++;
        end
        chk("push_wait", (n < 100), 1);
        step();
        op_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [15:0] exp);
        int n;
        n = 0;
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, res_valid, 1);
        chk(tag, res_product, exp);
        res_ready = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] exp_q [6];
    logic [7:0]  pa [6];
    logic [7:0]  pb [6];
    int          l0;
    int          got;
    int          cyc;
    bit          acc;
    bit          rv;
    bit          stable;
    bit          seen;
    bit          rdy_ok;
    logic [15:0] rp;

    initial begin
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_a      = 8'd0;
        op_b      = 8'd0;
        res_ready = 1'b0;
        #23;
        chk("rst_load", mul_load, 0);
        chk("rst_a", mul_a, 0);
        chk("rst_b", mul_b, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_prod", res_product, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        step();
        chk("rst_ready", op_ready, 1);

        // 3 * 5 with exact latency: load after T+1, result after T+12
        res_ready = 1'b1;
        l0 = loads;
        push(8'd3, 8'd5);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1)  chk("lat_load_hi", mul_load, 1);
            if (k == 2)  chk("lat_load_lo", mul_load, 0);
            if (k == 5)  chk("lat_a_held", mul_a, 8'd3);
            if (k == 11) chk("lat_rv_early", res_valid, 0);
            if (k == 12) begin
                chk("lat_rv", res_valid, 1);
                chk("lat_prod", res_product, 16'h000F);
                chk("lat_busy_hi", busy, 1);
            end
        end
        step();
        chk("lat_rv_drop", res_valid, 0);
        chk("lat_busy_lo", busy, 0);
        chk("lat_one_load", loads - l0, 1);

        push(8'hFC, 8'd7);
        get_result("neg4x7", 16'hFFE4);
        push(8'h80, 8'h80);
        get_result("m128sq", 16'h4000);

        // Backpressure: second pair must wait for the handshake
        res_ready = 1'b0;
        push(8'd5, 8'd6);
        push(8'd7, 8'hFD);
        cyc = 0;
        while (!res_valid && cyc < 40) begin
            step();
            cyc++;
        end
        chk("bp_valid", res_valid, 1);
        l0     = loads;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!res_valid || res_product !== 16'h001E || mul_a !== 8'd5) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_no_issue", loads - l0, 0);
        res_ready = 1'b1;
        step();
        chk("bp_issue_load", mul_load, 1);
        chk("bp_issue_a", mul_a, 8'd7);
        chk("bp_issue_b", mul_b, 8'hFD);
        get_result("bp_second", 16'hFFEB);

        // FIFO full: 4 buffered + 1 in flight, then drain in order
        pa = '{8'd1, 8'hFF, 8'd100, 8'd127, 8'h80, 8'd9};
        pb = '{8'd2, 8'hFF, 8'hCE, 8'd127, 8'd1, 8'hF7};
        exp_q = '{16'h0002, 16'h0001, 16'hEC78, 16'h3F01, 16'hFF80, 16'hFFAF};
        res_ready = 1'b0;
        step();
        rdy_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_a     = pa[i];
            op_b     = pb[i];
            op_valid = 1'b1;
            if (!op_ready) rdy_ok = 1'b0;
            step();
        end
        chk("full_rdy_before", rdy_ok, 1);
        chk("full_rdy_low", op_ready, 0);
        chk("full_model", booth(pa[2], pb[2]), exp_q[2]);
        op_a      = pa[5];
        op_b      = pb[5];
        res_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 200) begin
            acc = op_valid && op_ready;
            rv  = res_valid;
            rp  = res_product;
            step();
            cyc++;
            if (acc) op_valid = 1'b0;
            if (rv) begin
                chk($sformatf("full_res%0d", got), rp, exp_q[got]);
                got++;
            end
        end
        chk("full_count", got, 6);
        op_valid = 1'b0;

        // Reset during WAIT with cnt == 5
        push(8'd11, 8'd13);
        for (int k = 0; k < 7; k++) step();
        #2 reset = 1'b1;
        #1;
        chk("mid_load", mul_load, 0);
        chk("mid_a", mul_a, 0);
        chk("mid_b", mul_b, 0);
        chk("mid_rv", res_valid, 0);
        chk("mid_prod", res_product, 0);
        chk("mid_busy", busy, 0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (res_valid) seen = 1'b1;
        end
        chk("mid_no_result", seen, 0);
        push(8'd2, 8'hFD);
        get_result("post_rst", 16'hFFFA);

        // Zero operand
        res_ready = 1'b1;
        l0 = loads;
        push(8'd0, 8'hF9);
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
        step();
        chk("zb_rv", res_valid, 1);
        chk("zb_prod", res_product, 0);
        chk("zb_b", mul_b, 8'hF9);
        chk("zb_no_load", loads - l0, 0);
        step();
`else
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 11) chk("zero_rv_early", res_valid, 0);
            if (k == 12) begin
                chk("zero_rv", res_valid, 1);
                chk("zero_prod", res_product, 0);
            end
        end
        chk("zero_load", loads - l0, 1);
        step();
`endif
        chk("end_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
